// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial adder: default width and FSM state codes.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2-bit encoding; 2'b11 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester (master) and serial_adder (slave).
interface serial_adder_if #(
    parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the per-bit datapath of serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, through one full_adder.
module serial_adder
    import serial_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CNT_W-1:0] count;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    assign last_bit = (count == CNT_W'(WIDTH - 1));

    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all flops update
        // together from pre-edge values, regardless of statement order.
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        // NOTE: next_state gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            ST_IDLE: if (bus.start) next_state = ST_RUN;
            ST_RUN:  if (last_bit)  next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Operand capture, per-bit shift and carry feedback into the cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        carry  <= bus.cin;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        count  <= '0;
                    end
                end
                ST_RUN: begin
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    sum_q <= {fa_sum, sum_q[WIDTH-1:1]};
                    carry <= fa_cout;
                    count <= count + CNT_W'(1);
                    if (last_bit) cout_q <= fa_cout;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
